// File: rtl/adder_tree_accum_if.sv
// Sample-beat input bus and frame-result output bus of the adder tree accumulator.
interface adder_tree_accum_if #(
   parameter int NUM_INPUTS = 16,
   parameter int DWIDTH     = 14,
   parameter int OWIDTH     = 14,
   parameter int BEAT_LOG2  = 8
);
   logic [NUM_INPUTS*DWIDTH-1:0] i_dat_vector;
   logic                         i_dat_valid;
   logic                         i_dat_last;
   logic [OWIDTH-1:0]            o_sum;
   logic                         o_sum_valid;
   logic                         o_sat;
   logic [BEAT_LOG2:0]           o_frame_beats;

   modport master (
      output i_dat_vector, i_dat_valid, i_dat_last,
      input  o_sum, o_sum_valid, o_sat, o_frame_beats
   );

   modport slave (
      input  i_dat_vector, i_dat_valid, i_dat_last,
      output o_sum, o_sum_valid, o_sat, o_frame_beats
   );
endinterface

// File: rtl/adder_tree_accum.sv
// Pipelined adder tree reducing NUM_INPUTS samples per beat, followed by a frame
// accumulator with optional output saturation.
//
// state    | meaning
// ST_IDLE  | no beats collected; next valid beat starts a frame
// ST_OPEN  | frame in progress; acc_q/beats_q hold the partial sum
module adder_tree_accum #(
   parameter int NUM_INPUTS = 16,
   parameter int DWIDTH     = 14,
   parameter bit SIGNED     = 1'b0,
   parameter int BEAT_LOG2  = 8,
   parameter int OWIDTH     = 14,
   parameter bit SATURATE   = 1'b0
) (
   input logic               clk,
   input logic               rst,
   adder_tree_accum_if.slave bus
);
   localparam int LEVELS = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int TREE_W = DWIDTH + LEVELS;
   localparam int ACC_W  = TREE_W + BEAT_LOG2;
   localparam int BW     = BEAT_LOG2 + 1;

   function automatic int level_terms(input int lvl);
      int n;
      n = NUM_INPUTS;
      for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
      return n;
   endfunction

   typedef enum logic {ST_IDLE, ST_OPEN} state_t;

   logic [TREE_W-1:0] ext    [NUM_INPUTS];
   logic [TREE_W-1:0] node_d [LEVELS][NUM_INPUTS];
   logic [TREE_W-1:0] node_q [LEVELS][NUM_INPUTS];
   logic [LEVELS-1:0] vld_d, vld_q, lst_d, lst_q;

   always_comb begin
      for (int ii = 0; ii < NUM_INPUTS; ii++) begin
         ext[ii] = {{LEVELS{SIGNED & bus.i_dat_vector[DWIDTH*ii + DWIDTH-1]}},
                    bus.i_dat_vector[DWIDTH*ii +: DWIDTH]};
      end
   end

   // Every level pairs terms (2k, 2k+1); an odd leftover is registered unchanged.
   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int N_IN = level_terms(l);
      for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_node
         if (2*k+1 < N_IN) begin : g_add
            if (l == 0) begin : g_src_in
               assign node_d[l][k] = ext[2*k] + ext[2*k+1];
            end else begin : g_src_lvl
               assign node_d[l][k] = node_q[l-1][2*k] + node_q[l-1][2*k+1];
            end
         end else if (2*k+1 == N_IN) begin : g_pass
            if (l == 0) begin : g_src_in
               assign node_d[l][k] = ext[2*k];
            end else begin : g_src_lvl
               assign node_d[l][k] = node_q[l-1][2*k];
            end
         end else begin : g_zero
            assign node_d[l][k] = '0;
         end
      end
   end

   always_comb begin
      vld_d    = '0;
      lst_d    = '0;
      vld_d[0] = bus.i_dat_valid;
      lst_d[0] = bus.i_dat_last;
      for (int i = 1; i < LEVELS; i++) begin
         vld_d[i] = vld_q[i-1];
         lst_d[i] = lst_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      node_q <= node_d;
      lst_q  <= lst_d;
   end

   state_t            state_q;
   logic [ACC_W-1:0]  acc_q, tree_ext, acc_next;
   logic [BW-1:0]     beats_q, beats_next, frame_beats_q;
   logic [OWIDTH-1:0] sum_d, sum_q;
   logic              sat_d, sat_q, sum_valid_q;
   logic [TREE_W-1:0] tree_sum;
   logic              tree_vld, tree_lst, first;

   assign tree_sum = node_q[LEVELS-1][0];
   assign tree_vld = vld_q[LEVELS-1];
   assign tree_lst = lst_q[LEVELS-1];

   always_comb begin
      tree_ext   = {{BEAT_LOG2{SIGNED & tree_sum[TREE_W-1]}}, tree_sum};
      first      = (state_q == ST_IDLE);
      acc_next   = (first ? '0 : acc_q) + tree_ext;
      beats_next = first ? BW'(1) : ((&beats_q) ? beats_q : beats_q + 1'b1);
   end

   if (OWIDTH >= ACC_W) begin : g_wide
      always_comb begin
         sat_d = 1'b0;
         sum_d = SIGNED ? OWIDTH'($signed(acc_next)) : OWIDTH'(acc_next);
      end
   end else if (SIGNED) begin : g_sgn
      localparam logic [OWIDTH-1:0] SMIN = OWIDTH'(1) << (OWIDTH-1);
      always_comb begin
         sat_d = (acc_next[ACC_W-1:OWIDTH-1] != '0) && (acc_next[ACC_W-1:OWIDTH-1] != '1);
         sum_d = acc_next[OWIDTH-1:0];
         if (SATURATE && sat_d) sum_d = acc_next[ACC_W-1] ? SMIN : ~SMIN;
      end
   end else begin : g_uns
      always_comb begin
         sat_d = |acc_next[ACC_W-1:OWIDTH];
         sum_d = (SATURATE && sat_d) ? '1 : acc_next[OWIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q         <= '0;
         state_q       <= ST_IDLE;
         acc_q         <= '0;
         beats_q       <= '0;
         sum_q         <= '0;
         sat_q         <= 1'b0;
         sum_valid_q   <= 1'b0;
         frame_beats_q <= '0;
      end else begin
         vld_q       <= vld_d;
         sum_valid_q <= 1'b0;
         if (tree_vld) begin
            if (tree_lst) begin
               sum_q         <= sum_d;
               sat_q         <= sat_d;
               frame_beats_q <= beats_next;
               sum_valid_q   <= 1'b1;
               acc_q         <= '0;
               beats_q       <= '0;
               state_q       <= ST_IDLE;
            end else begin
               acc_q   <= acc_next;
               beats_q <= beats_next;
               state_q <= ST_OPEN;
            end
         end
      end
   end

   assign bus.o_sum         = sum_q;
   assign bus.o_sum_valid   = sum_valid_q;
   assign bus.o_sat         = sat_q;
   assign bus.o_frame_beats = frame_beats_q;
endmodule
